bcd_down_timer: RTL and testbench

- Loadable multi-digit BCD countdown timer: the down-counting counterpart of the team's prescaled BCD up counters.
- A prescaler divides the clock. Each prescaler tick decrements a packed BCD value by one.
- On reaching zero it raises a one-cycle done pulse and stops.
- Sits between control logic (load/start/pause) and the digit display path, which consumes out directly.

---
 rtl/bcd_down_timer_pkg.sv | 19 +
 rtl/bcd_down_timer_digit_dec.sv | 26 ++
 rtl/bcd_down_timer.sv | 112 +++++++++++
 tb/tb_bcd_down_timer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_down_timer_pkg.sv
// Shared definitions for the BCD countdown timer: FSM state encoding,
// the BCD digit width and the load-time digit clamp.
package bcd_down_timer_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Force a non-BCD nibble (A..F) to 9 so out always holds legal digits.
    function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

endpackage

// File: rtl/bcd_down_timer_digit_dec.sv
// One BCD digit of the ripple decrementer. A borrow into a zero digit
// wraps it to 9 and passes the borrow on to the next digit.
module bcd_digit_dec
    import bcd_down_timer_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    input  logic             borrow_in,
    output logic [BCD_W-1:0] digit_next,
    output logic             borrow_out
);

    // Decrement the digit only when a borrow arrives from below.
    always_comb begin
        digit_next = digit;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (digit == '0) begin
                digit_next = 4'd9;
                borrow_out = 1'b1;
            end else begin
                digit_next = digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_down_timer.sv
// Loadable NDIG-digit BCD countdown timer. A free-running prescaler in
// RUN produces one tick every PRESCALE cycles; each tick decrements the
// packed BCD value, and reaching zero stops the count with a done pulse.
module bcd_down_timer
    import bcd_down_timer_pkg::*;
#(
    parameter int PRESCALE = 1000,
    parameter int NDIG     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*NDIG-1:0]     load_val,
    input  logic                  start,
    input  logic                  pause,
    output logic [4*NDIG-1:0]     out,
    output logic                  busy,
    output logic                  done
);

    localparam logic [10:0] PS_LAST = 11'(PRESCALE - 1);

    state_t              state;
    logic [10:0]         presc;
    logic                tick;
    logic                last_step;
    logic [4*NDIG-1:0]   dec_val;
    logic [4*NDIG-1:0]   clamp_val;
    logic [NDIG:0]       borrow;

    assign tick      = (presc == PS_LAST);
    assign borrow[0] = 1'b1;

    // Decrement chain across all digits plus per-digit load clamp.
    for (genvar g = 0; g < NDIG; g++) begin : g_dig
        bcd_digit_dec u_dig (
            .digit      (out[g*BCD_W +: BCD_W]),
            .borrow_in  (borrow[g]),
            .digit_next (dec_val[g*BCD_W +: BCD_W]),
            .borrow_out (borrow[g+1])
        );
        assign clamp_val[g*BCD_W +: BCD_W] = bcd_clamp(load_val[g*BCD_W +: BCD_W]);
    end

    // A borrow out of the top digit would mean underflow; treat it like
    // reaching zero so the value can never wrap to all nines.
    assign last_step = (dec_val == '0) || borrow[NDIG];

    // Control FSM, prescaler and value register; load overrides everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            presc <= '0;
            out   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                out   <= clamp_val;
                presc <= '0;
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            presc <= '0;
                            if (out != '0) begin
                                state <= RUN;
                                busy  <= 1'b1;
                            end else begin
                                state <= DONE;
                                done  <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (pause && !start) begin
                            state <= PAUSED;
                        end else if (tick) begin
                            presc <= '0;
                            if (last_step) begin
                                out   <= '0;
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                out <= dec_val;
                            end
                        end else begin
                            presc <= presc + 11'd1;
                        end
                    end
                    PAUSED: begin
                        if (start) begin
                            state <= RUN;
                        end
                    end
                    DONE: begin
                        out <= '0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bcd_down_timer.sv
// Scoreboard bench for bcd_down_timer: a 2-digit and a 3-digit instance,
// both with PRESCALE=4. Stimulus pushes expected out/busy values tagged
// with the clock edge they belong to, plus expected done-pulse edges; a
// negedge monitor pops and compares them independently.
module tb_bcd_down_timer;

    localparam int PS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        load = 1'b0, start = 1'b0, pause = 1'b0;
    logic [7:0]  load_val = '0;
    logic [7:0]  out;
    logic        busy, done;
    logic        load1 = 1'b0, start1 = 1'b0, pause1 = 1'b0;
    logic [11:0] load_val1 = '0;
    logic [11:0] out1;
    logic        busy1, done1;

    bcd_down_timer #(.PRESCALE(PS), .NDIG(2)) u0 (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val),
        .start(start), .pause(pause), .out(out), .busy(busy), .done(done)
    );

    bcd_down_timer #(.PRESCALE(PS), .NDIG(3)) u1 (
        .clk(clk), .rst(rst), .load(load1), .load_val(load_val1),
        .start(start1), .pause(pause1), .out(out1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        int          e;
        bit          unit;
        logic [11:0] o;
        logic        b;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   dq0[$];
    int   dq1[$];

    task automatic exp_at(input int e, input bit unit, input logic [11:0] o,
                          input logic b, input string nm);
        exp_t x;
        x.e = e; x.unit = unit; x.o = o; x.b = b; x.nm = nm;
        q.push_back(x);
    endtask

    // Monitor: value/busy scoreboard and done-pulse scoreboard.
    always @(negedge clk) begin
        exp_t        x;
        logic [11:0] ao;
        logic        ab;
        while (q.size() > 0 && q[0].e <= cyc) begin
            x = q.pop_front();
            n_vec++;
            if (x.e < cyc) begin
                n_bad++;
                $display("FAIL %s: check for edge %0d skipped (now %0d)", x.nm, x.e, cyc);
            end else begin
                ao = x.unit ? out1 : {4'h0, out};
                ab = x.unit ? busy1 : busy;
                if (ao !== x.o || ab !== x.b) begin
                    n_bad++;
                    $display("FAIL %s edge %0d: out=%h busy=%b, required out=%h busy=%b",
                             x.nm, cyc, ao, ab, x.o, x.b);
                end
            end
        end
        if (done === 1'b1) begin
            n_vec++;
            if (dq0.size() > 0 && dq0[0] == cyc) begin
                void'(dq0.pop_front());
            end else begin
                n_bad++;
                $display("FAIL done0: pulse=1 at edge %0d, required 0", cyc);
            end
        end else if (dq0.size() > 0 && dq0[0] <= cyc) begin
            n_vec++;
            n_bad++;
            $display("FAIL done0: pulse=%b at edge %0d, required 1", done, dq0[0]);
            void'(dq0.pop_front());
        end
        if (done1 === 1'b1) begin
            n_vec++;
            if (dq1.size() > 0 && dq1[0] == cyc) begin
                void'(dq1.pop_front());
            end else begin
                n_bad++;
                $display("FAIL done1: pulse=1 at edge %0d, required 0", cyc);
            end
        end else if (dq1.size() > 0 && dq1[0] <= cyc) begin
            n_vec++;
            n_bad++;
            $display("FAIL done1: pulse=%b at edge %0d, required 1", done1, dq1[0]);
            void'(dq1.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_to(input int e);
        while (cyc < e) step();
    endtask

    task automatic cmd(input bit l, input logic [7:0] lv, input bit s, input bit p);
        load = l; load_val = lv; start = s; pause = p;
        step();
        load = 1'b0; start = 1'b0; pause = 1'b0;
    endtask

    task automatic cmd1(input bit l, input logic [11:0] lv, input bit s);
        load1 = l; load_val1 = lv; start1 = s;
        step();
        load1 = 1'b0; start1 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int e;
        rst = 1'b1;
        #1 rst = 1'b0;
        exp_at(2, 1'b0, 12'h000, 1'b0, "reset_u0");
        exp_at(2, 1'b1, 12'h000, 1'b0, "reset_u1");
        step_to(3);
        rst = 1'b1;

        // Reset mid-run
        cmd(1'b1, 8'h25, 1'b0, 1'b0); e = cyc;
        exp_at(e, 1'b0, 12'h025, 1'b0, "load25");
        cmd(1'b0, 8'h00, 1'b1, 1'b0); e = cyc;
        exp_at(e,     1'b0, 12'h025, 1'b1, "start25");
        exp_at(e + 4, 1'b0, 12'h024, 1'b1, "dec24");
        exp_at(e + 6, 1'b0, 12'h000, 1'b0, "rst_abort");
        step_to(e + 6);
        #2 rst = 1'b0;
        step();
        exp_at(cyc, 1'b0, 12'h000, 1'b0, "rst_hold");
        rst = 1'b1;
        step();

        // Basic countdown 03 -> 00
        cmd(1'b1, 8'h03, 1'b0, 1'b0); e = cyc;
        exp_at(e, 1'b0, 12'h003, 1'b0, "load03");
        cmd(1'b0, 8'h00, 1'b1, 1'b0); e = cyc;
        exp_at(e,      1'b0, 12'h003, 1'b1, "run03");
        exp_at(e + 3,  1'b0, 12'h003, 1'b1, "pre_tick");
        exp_at(e + 4,  1'b0, 12'h002, 1'b1, "dec02");
        exp_at(e + 8,  1'b0, 12'h001, 1'b1, "dec01");
        exp_at(e + 12, 1'b0, 12'h000, 1'b0, "dec00");
        exp_at(e + 13, 1'b0, 12'h000, 1'b0, "done_hold");
        dq0.push_back(e + 12);
        step_to(e + 14);
        cmd(1'b0, 8'h00, 1'b1, 1'b0);
        exp_at(e + 17, 1'b0, 12'h000, 1'b0, "done_start_ign");
        step_to(e + 18);

        // Borrow ripple 10 -> 09
        cmd(1'b1, 8'h10, 1'b0, 1'b0);
        cmd(1'b0, 8'h00, 1'b1, 1'b0); e = cyc;
        exp_at(e + 3, 1'b0, 12'h010, 1'b1, "pre_borrow");
        exp_at(e + 4, 1'b0, 12'h009, 1'b1, "borrow09");
        step_to(e + 5);

        // Three-digit instance: clamp, zero load, zero start
        cmd1(1'b1, 12'hA5C, 1'b0); e = cyc;
        exp_at(e, 1'b1, 12'h959, 1'b0, "clamp3");
        cmd1(1'b1, 12'h000, 1'b0); e = cyc;
        exp_at(e, 1'b1, 12'h000, 1'b0, "load000");
        cmd1(1'b0, 12'h000, 1'b1); e = cyc;
        exp_at(e,     1'b1, 12'h000, 1'b0, "zero3_start");
        exp_at(e + 2, 1'b1, 12'h000, 1'b0, "zero3_hold");
        dq1.push_back(e);
        step_to(e + 3);

        // Pause / resume
        cmd(1'b1, 8'h05, 1'b0, 1'b0);
        cmd(1'b0, 8'h00, 1'b1, 1'b0); e = cyc;
        step_to(e + 2);
        cmd(1'b0, 8'h00, 1'b0, 1'b1);
        exp_at(e + 3,  1'b0, 12'h005, 1'b1, "paused");
        exp_at(e + 8,  1'b0, 12'h005, 1'b1, "paused_mid");
        exp_at(e + 13, 1'b0, 12'h005, 1'b1, "paused_end");
        step_to(e + 13);
        cmd(1'b0, 8'h00, 1'b1, 1'b0); e = cyc;
        exp_at(e,     1'b0, 12'h005, 1'b1, "resume");
        exp_at(e + 1, 1'b0, 12'h005, 1'b1, "resume_pre");
        exp_at(e + 2, 1'b0, 12'h004, 1'b1, "resume_dec");
        step_to(e + 2);

        // Clamp and load-over-start priority
        cmd(1'b1, 8'hAF, 1'b1, 1'b0); e = cyc;
        exp_at(e,     1'b0, 12'h099, 1'b0, "clamp99");
        exp_at(e + 1, 1'b0, 12'h099, 1'b0, "no_autostart");
        step();
        cmd(1'b0, 8'h00, 1'b1, 1'b0); e = cyc;
        exp_at(e + 3, 1'b0, 12'h099, 1'b1, "run99");
        exp_at(e + 4, 1'b0, 12'h098, 1'b1, "dec98");
        step_to(e + 4);

        // Abort by load during RUN
        cmd(1'b1, 8'h02, 1'b0, 1'b0);
        cmd(1'b0, 8'h00, 1'b1, 1'b0); e = cyc;
        exp_at(e, 1'b0, 12'h002, 1'b1, "run02");
        step_to(e + 2);
        cmd(1'b1, 8'h07, 1'b0, 1'b0);
        exp_at(e + 3,  1'b0, 12'h007, 1'b0, "abort07");
        exp_at(e + 10, 1'b0, 12'h007, 1'b0, "abort_hold");
        step_to(e + 10);

        // Zero start, then extra starts in DONE
        cmd(1'b1, 8'h00, 1'b0, 1'b0); e = cyc;
        exp_at(e, 1'b0, 12'h000, 1'b0, "load00");
        cmd(1'b0, 8'h00, 1'b1, 1'b0); e = cyc;
        exp_at(e, 1'b0, 12'h000, 1'b0, "zero_start");
        dq0.push_back(e);
        cmd(1'b0, 8'h00, 1'b1, 1'b0);
        cmd(1'b0, 8'h00, 1'b1, 1'b0);
        exp_at(e + 4, 1'b0, 12'h000, 1'b0, "done_restart_ign");
        step_to(e + 6);

        if (dq0.size() > 0 || dq1.size() > 0 || q.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL leftover: pending done0=%0d done1=%0d checks=%0d, required 0",
                     dq0.size(), dq1.size(), q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
